// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// -------------
// Two-entry pipeline register with a valid/ready handshake on both sides.
// The main register drives out_data/out_valid. A skid register catches the
// one word that arrives while the consumer stalls. in_ready comes straight
// from a flop, so there is no combinational path from out_ready to in_ready.
// A synchronous flush squashes every held word for branch or exception
// recovery.
//
// Ports
//   clk        clock; all state changes happen on its rising edge
//   rst        synchronous, active-high reset (has priority over everything)
//   flush      synchronous squash of all held words
//   in_valid   upstream presents a word on in_data
//   in_ready   stage can accept a word this cycle (registered)
//   in_data    upstream word
//   out_valid  out_data holds a valid word
//   out_ready  downstream takes the word this cycle
//   out_data   word presented downstream (registered)
module pipe_skid_reg #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   main_q, main_d;
  logic [width-1:0]   skid_q, skid_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic               in_xfer;
  logic               out_xfer;

  // Handshakes use the registered flags, which match the outputs seen by
  // the neighbouring stages.
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Held words are dropped. main keeps its bits, and only the valid flag
      // goes low. A coincident input word is discarded.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            // The consumer stalled. Park the new word behind the current one.
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // Both flags are decoded from the next state, so each output is a
    // plain flop.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
// ----------------
// Scoreboard bench for pipe_skid_reg. A queue models the words held by the
// stage. Accepted input words are pushed, and taken output words are popped.
// Before each edge the DUT outputs are compared with the model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic        live = 1'b0;
  logic        last_in_acc = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare at the falling edge. Then update the model for the coming
  // rising edge, and return 1 ns after that edge.
  task automatic tick();
    logic exp_valid, exp_ready, in_acc, out_acc;
    @(negedge clk);
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() < 2);
    if (live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (exp_valid) chk("out_data", out_data, sb[0]);
    end
    in_acc      = in_valid & exp_ready;
    out_acc     = exp_valid & out_ready;
    last_in_acc = 1'b0;
    if (rst) begin
      sb.delete();
      live = 1'b1;
    end else if (flush) begin
      if (out_acc) $display("flush: word %h taken with flush", sb[0]);
      sb.delete();
    end else begin
      if (out_acc) begin
        $display("out word %h", sb[0]);
        void'(sb.pop_front());
      end
      if (in_acc) begin
        sb.push_back(in_data);
        last_in_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the stage takes it (bounded).
  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_in_acc) break;
    end
    if (!last_in_acc) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;

    // Reset for two edges with a handshake pending.
    idle(2);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    idle(3);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1;
      in_data  = v;
      tick();
      chk("stream_acc", {31'd0, last_in_acc}, 32'd1);
    end
    in_valid = 1'b0;
    idle(3);

    // Stall and skid: 2 and 3 fill the stage, and 4 has to wait.
    out_ready = 1'b0;
    push(32'd2);
    push(32'd3);
    in_valid = 1'b1; in_data = 32'd4;
    idle(3);
    chk("skid_block", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    push(32'd4);
    idle(3);

    // Stall hold: 5 must stay put while in_data wanders.
    out_ready = 1'b0;
    push(32'd5);
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      tick();
      chk("hold_data", out_data, 32'd5);
    end
    out_ready = 1'b1;
    idle(2);

    // Flush while two words are held, with 9 offered at the same edge.
    out_ready = 1'b0;
    push(32'd7);
    push(32'd8);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    idle(3);

    // Reset mid-operation with two words held.
    out_ready = 1'b0;
    push(32'd10);
    push(32'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_data", out_data, 32'd0);
    out_ready = 1'b1;
    push(32'd12);
    chk("rst2_first", out_data, 32'd12);
    idle(2);

    // Random traffic with occasional flushes. in_data is held until the
    // stage accepts it.
    in_data = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || last_in_acc) begin
        if (last_in_acc) in_data = in_data + 1;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
